// File: rtl/iter_branch_cmp.sv
// Multi-cycle branch comparator: scans operands CHUNK bits per cycle, MSB chunk
// first, stopping at the first differing chunk, and resolves one of eight conditions.
module iter_branch_cmp #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             cmp,
   output logic             eq,
   output logic             lt
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCHUNK - 1);
   localparam logic [IDXW-1:0]  IDX_ZERO = {IDXW{1'b0}};
   localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1'b1) << (CHUNK - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Modes 010, 011, 110 and 111 order operands as two's complement.
   function automatic logic is_signed_mode(input logic [2:0] m);
      is_signed_mode = m[1];
   endfunction

   function automatic logic branch_result(input logic [2:0] m, input logic e, input logic l);
      case (m)
         3'b000:         branch_result = e;
         3'b001:         branch_result = !e;
         3'b010, 3'b100: branch_result = l;
         3'b011, 3'b101: branch_result = !l;
         3'b110:         branch_result = l | e;
         3'b111:         branch_result = !(l | e);
         default:        branch_result = 1'b0;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       mode_q, mode_d;
   logic             cmp_q, cmp_d;
   logic             eq_q, eq_d;
   logic             lt_q, lt_d;
   logic             busy_q, done_q;

   logic [CHUNK-1:0] chunk_a_s, chunk_b_s;
   logic             chunk_lt_s, chunk_ne_s;

   // Select the current chunk; flipping the sign bit turns signed order into unsigned order.
   always_comb begin
      chunk_a_s = a_q[idx_q*CHUNK +: CHUNK];
      chunk_b_s = b_q[idx_q*CHUNK +: CHUNK];
      if (is_signed_mode(mode_q) && (idx_q == IDX_TOP)) begin
         chunk_a_s = chunk_a_s ^ MSB_MASK;
         chunk_b_s = chunk_b_s ^ MSB_MASK;
      end else begin
         chunk_a_s = chunk_a_s;
         chunk_b_s = chunk_b_s;
      end
      chunk_lt_s = (chunk_a_s < chunk_b_s);
      chunk_ne_s = (chunk_a_s != chunk_b_s);
   end

   // Next-state and datapath update for the IDLE/SCAN/DONE controller.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      mode_d  = mode_q;
      cmp_d   = cmp_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = (mode[2:1] == 2'b11) ? {WIDTH{1'b0}} : b;
               mode_d  = mode;
               idx_d   = IDX_TOP;
               cmp_d   = 1'b0;
               eq_d    = 1'b0;
               lt_d    = 1'b0;
               state_d = S_SCAN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SCAN: begin
            if (chunk_ne_s) begin
               eq_d    = 1'b0;
               lt_d    = chunk_lt_s;
               cmp_d   = branch_result(mode_q, 1'b0, chunk_lt_s);
               state_d = S_DONE;
            end else if (idx_q == IDX_ZERO) begin
               eq_d    = 1'b1;
               lt_d    = 1'b0;
               cmp_d   = branch_result(mode_q, 1'b1, 1'b0);
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q - {{(IDXW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, operand and result registers; busy/done are registered off the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= IDX_ZERO;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         mode_q  <= 3'b000;
         cmp_q   <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mode_q  <= mode_d;
         cmp_q   <= cmp_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         busy_q  <= (state_d == S_SCAN);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign cmp  = cmp_q;
   assign eq   = eq_q;
   assign lt   = lt_q;

endmodule

// File: tb/tb_iter_branch_cmp.sv
// Table-driven bench for iter_branch_cmp (WIDTH=32, CHUNK=8) plus handshake
// and mid-scan reset sequences.
module tb_iter_branch_cmp;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  mode;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        cmp;
   logic        eq;
   logic        lt;

   int errors;
   int checks;

   typedef struct {
      logic [2:0]  mode;
      logic [31:0] a;
      logic [31:0] b;
      int          k;
      logic        cmp;
      logic        eq;
      logic        lt;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   iter_branch_cmp #(.WIDTH(32), .CHUNK(8)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mode  (mode),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .cmp   (cmp),
      .eq    (eq),
      .lt    (lt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Counts busy cycles from the current negedge until done rises (bounded).
   task automatic wait_done(input string nm, output int k);
      int guard;
      k = 0;
      guard = 0;
      while (done !== 1'b1 && guard < 64) begin
         if (busy === 1'b1) k++;
         @(negedge clk);
         guard++;
      end
      if (guard >= 64) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done within %0d cycles expected done", nm, guard);
      end
   endtask

   task automatic run_vec(input int i);
      int    k;
      string nm;
      nm = $sformatf("vec%0d", i);
      @(negedge clk);
      start = 1'b1;
      mode  = vecs[i].mode;
      a     = vecs[i].a;
      b     = vecs[i].b;
      @(negedge clk);
      start = 1'b0;
      mode  = ~vecs[i].mode;
      a     = ~vecs[i].a;
      b     = ~vecs[i].b;
      wait_done(nm, k);
      chk({nm, "_k"},    32'(k),    32'(vecs[i].k));
      chk({nm, "_done"}, 32'(done), 32'd1);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_cmp"},  32'(cmp),  32'(vecs[i].cmp));
      chk({nm, "_eq"},   32'(eq),   32'(vecs[i].eq));
      chk({nm, "_lt"},   32'(lt),   32'(vecs[i].lt));
      @(negedge clk);
      chk({nm, "_done_drop"}, 32'(done), 32'd0);
      chk({nm, "_cmp_hold"},  32'(cmp),  32'(vecs[i].cmp));
   endtask

   initial begin
      int k;
      errors = 0;
      checks = 0;
      start  = 1'b0;
      mode   = 3'b000;
      a      = 32'h0;
      b      = 32'h0;
      reset  = 1'b1;

      //            mode    a             b             k  cmp   eq    lt
      vecs[0]  = '{3'b000, 32'h12345678, 32'h12345678, 4, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{3'b001, 32'h12345678, 32'h12345678, 4, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 1, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{3'b100, 32'hFFFFFFFF, 32'h00000001, 1, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{3'b001, 32'h12005678, 32'h12345678, 2, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{3'b001, 32'h12345679, 32'h12345678, 4, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{3'b110, 32'h00000000, 32'hDEADBEEF, 4, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{3'b111, 32'h80000000, 32'hDEADBEEF, 1, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{3'b111, 32'h00000001, 32'hDEADBEEF, 4, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{3'b011, 32'h00000005, 32'hFFFFFFFF, 1, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{3'b010, 32'h7FFF0080, 32'h7FFF0100, 3, 1'b1, 1'b0, 1'b1};
      vecs[12] = '{3'b010, 32'h00000080, 32'h00000001, 4, 1'b0, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cmp",  32'(cmp),  32'd0);
      chk("rst_eq",   32'(eq),   32'd0);
      chk("rst_lt",   32'(lt),   32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NVEC; i++) begin
         run_vec(i);
      end

      // start pulsed during SCAN with other operands must be ignored
      @(negedge clk);
      start = 1'b1; mode = 3'b000; a = 32'h12345678; b = 32'h12345678;
      @(negedge clk);
      chk("ign_busy1", 32'(busy), 32'd1);
      start = 1'b1; mode = 3'b010; a = 32'h00000000; b = 32'h00000001;
      @(negedge clk);
      start = 1'b0;
      wait_done("ign", k);
      chk("ign_k",   32'(k + 1), 32'd4);
      chk("ign_cmp", 32'(cmp),   32'd1);
      chk("ign_eq",  32'(eq),    32'd1);
      chk("ign_lt",  32'(lt),    32'd0);
      @(negedge clk);

      // back-to-back: start held during DONE is accepted immediately
      @(negedge clk);
      start = 1'b1; mode = 3'b001; a = 32'h12005678; b = 32'h12345678;
      @(negedge clk);
      start = 1'b0;
      wait_done("b2b_first", k);
      chk("b2b_k1",    32'(k),    32'd2);
      chk("b2b_cmp1",  32'(cmp),  32'd1);
      start = 1'b1; mode = 3'b100; a = 32'h00000001; b = 32'h00000002;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy",  32'(busy), 32'd1);
      chk("b2b_ndone", 32'(done), 32'd0);
      chk("b2b_clr",   32'(cmp),  32'd0);
      wait_done("b2b_second", k);
      chk("b2b_k2",    32'(k),    32'd4);
      chk("b2b_cmp2",  32'(cmp),  32'd1);
      chk("b2b_eq2",   32'(eq),   32'd0);
      chk("b2b_lt2",   32'(lt),   32'd1);
      @(negedge clk);

      // reset on the second SCAN cycle aborts the scan without a done pulse
      @(negedge clk);
      start = 1'b1; mode = 3'b000; a = 32'hCAFEF00D; b = 32'hCAFEF00D;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rmid_busy", 32'(busy), 32'd0);
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         chk($sformatf("rmid_done%0d", j), 32'(done), 32'd0);
      end
      chk("rmid_cmp", 32'(cmp), 32'd0);
      chk("rmid_eq",  32'(eq),  32'd0);
      chk("rmid_lt",  32'(lt),  32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
